// File: rtl/cla_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module      : cla_adder_pipe
// Description : 2-stage pipelined two-level carry-lookahead adder/subtractor
//               with valid/ready handshakes. Define CLA_ADDER_PIPE_SAT_EN to
//               add the saturating-result input 'sat'.
// Revision    : 1.0 - initial release
// ============================================================================
module cla_adder_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
`ifdef CLA_ADDER_PIPE_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int NG = WIDTH / 4;

  if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_width_check
    $error("cla_adder_pipe: WIDTH must be a multiple of 4 in 4..64");
  end

  logic [WIDTH-1:0] w_b_eff, w_p, w_g;
  logic [NG-1:0]    w_pg, w_gg;
  logic             w_cin_eff, w_s2_adv, w_accept;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_p, r_g;
  logic [NG-1:0]    r_pg, r_gg;
  logic             r_cin;

  logic             r_out_valid, r_c_out, r_ovf, r_zero;
  logic [WIDTH-1:0] r_sum;

  assign w_b_eff   = b ^ {WIDTH{sub}};
  assign w_cin_eff = sub | c_in;
  assign w_p       = a ^ w_b_eff;
  assign w_g       = a & w_b_eff;

  assign w_s2_adv  = ~r_out_valid | out_ready;
  assign in_ready  = ~rst & (~r_s1_valid | w_s2_adv);
  assign w_accept  = in_valid & in_ready;

  always_comb begin
    w_pg = '0;
    w_gg = '0;
    for (int k = 0; k < NG; k++) begin
      w_pg[k] = &w_p[4*k +: 4];
      w_gg[k] = w_g[4*k+3]
              | (w_p[4*k+3] & w_g[4*k+2])
              | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
              | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
    end
  end

`ifdef CLA_ADDER_PIPE_SAT_EN
  logic r_sat;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_p        <= '0;
      r_g        <= '0;
      r_pg       <= '0;
      r_gg       <= '0;
      r_cin      <= 1'b0;
`ifdef CLA_ADDER_PIPE_SAT_EN
      r_sat      <= 1'b0;
`endif
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_p        <= w_p;
      r_g        <= w_g;
      r_pg       <= w_pg;
      r_gg       <= w_gg;
      r_cin      <= w_cin_eff;
`ifdef CLA_ADDER_PIPE_SAT_EN
      r_sat      <= sat;
`endif
    end else if (w_s2_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Each carry is an OR of generate terms gated by the propagates above them,
  // expanded fully so no carry waits on a neighbouring carry.
  logic [NG:0]      w_cg;
  logic [WIDTH-1:0] w_carry;
  logic             w_unused_g3;

  always_comb begin
    logic v_prod, v_acc;
    v_prod  = 1'b1;
    v_acc   = 1'b0;
    w_cg    = '0;
    w_cg[0] = r_cin;
    for (int k = 0; k < NG; k++) begin
      v_prod = 1'b1;
      v_acc  = 1'b0;
      for (int j = k; j >= 0; j--) begin
        v_acc  = v_acc | (v_prod & r_gg[j]);
        v_prod = v_prod & r_pg[j];
      end
      w_cg[k+1] = v_acc | (v_prod & r_cin);
    end
  end

  always_comb begin
    logic v_prod, v_acc;
    v_prod      = 1'b1;
    v_acc       = 1'b0;
    w_carry     = '0;
    w_unused_g3 = 1'b0;
    for (int k = 0; k < NG; k++) begin
      w_unused_g3 = w_unused_g3 ^ r_g[4*k+3];
      for (int bi = 0; bi < 4; bi++) begin
        v_prod = 1'b1;
        v_acc  = 1'b0;
        for (int j = bi - 1; j >= 0; j--) begin
          v_acc  = v_acc | (v_prod & r_g[4*k+j]);
          v_prod = v_prod & r_p[4*k+j];
        end
        w_carry[4*k+bi] = v_acc | (v_prod & w_cg[k]);
      end
    end
  end

  logic [WIDTH-1:0] w_sum_raw, w_sum_fin;
  logic             w_c_out, w_ovf;

  assign w_sum_raw = r_p ^ w_carry;
  assign w_c_out   = w_cg[NG];
  assign w_ovf     = w_carry[WIDTH-1] ^ w_c_out;

`ifdef CLA_ADDER_PIPE_SAT_EN
  localparam logic [WIDTH-1:0] c_smax = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] c_smin = {1'b1, {(WIDTH-1){1'b0}}};
  // On overflow a negative raw MSB means the true result was positive.
  assign w_sum_fin = (r_sat & w_ovf) ? (w_sum_raw[WIDTH-1] ? c_smax : c_smin)
                                     : w_sum_raw;
`else
  assign w_sum_fin = w_sum_raw;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_c_out     <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      r_sum       <= w_sum_fin;
      r_c_out     <= w_c_out;
      r_ovf       <= w_ovf;
      r_zero      <= (w_sum_fin == '0);
    end
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign c_out     = r_c_out;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_cla_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_cla_adder_pipe
// Description : Directed self-checking bench for cla_adder_pipe (16/64/4 bit).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cla_adder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1, c_in = 1'b0, sub = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        in_ready, out_valid, c_out, ovf, zero;
  logic [15:0] sum;

  logic        iv64 = 1'b0, ci64 = 1'b0, sb64 = 1'b0, ir64, ov64, co64, of64, z64;
  logic [63:0] a64 = '0, b64 = '0, s64;
  logic        iv4 = 1'b0, ci4 = 1'b0, sb4 = 1'b0, ir4, ov4, co4, of4, z4;
  logic [3:0]  a4 = '0, b4 = '0, s4;

  cla_adder_pipe #(.WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub),
`ifdef CLA_ADDER_PIPE_SAT_EN
    .sat(1'b0),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .c_out(c_out), .ovf(ovf), .zero(zero));

  cla_adder_pipe #(.WIDTH(64)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64),
    .a(a64), .b(b64), .c_in(ci64), .sub(sb64),
`ifdef CLA_ADDER_PIPE_SAT_EN
    .sat(1'b0),
`endif
    .out_valid(ov64), .out_ready(1'b1), .sum(s64),
    .c_out(co64), .ovf(of64), .zero(z64));

  cla_adder_pipe #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4),
    .a(a4), .b(b4), .c_in(ci4), .sub(sb4),
`ifdef CLA_ADDER_PIPE_SAT_EN
    .sat(1'b0),
`endif
    .out_valid(ov4), .out_ready(1'b1), .sum(s4),
    .c_out(co4), .ovf(of4), .zero(z4));

  int n_cmp = 0, n_err = 0;
  int acc_cnt = 0, res_cnt = 0;
  logic [16:0] exp_q[$];
  logic [65:0] q64[$];
  logic [5:0]  q4[$];

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [16:0] ref16(logic [15:0] x, logic [15:0] y, logic ci, logic s);
    logic [15:0] ye;
    ye = y ^ {16{s}};
    return {1'b0, x} + {1'b0, ye} + {16'd0, s | ci};
  endfunction

  function automatic logic [65:0] ref64(logic [63:0] x, logic [63:0] y, logic ci, logic s);
    logic [63:0] ye;
    logic [64:0] r;
    ye = y ^ {64{s}};
    r  = {1'b0, x} + {1'b0, ye} + {64'd0, s | ci};
    return {(x[63] == ye[63]) && (r[63] != x[63]), r};
  endfunction

  function automatic logic [5:0] ref4(logic [3:0] x, logic [3:0] y, logic ci, logic s);
    logic [3:0] ye;
    logic [4:0] r;
    ye = y ^ {4{s}};
    r  = {1'b0, x} + {1'b0, ye} + {4'd0, s | ci};
    return {(x[3] == ye[3]) && (r[3] != x[3]), r};
  endfunction

  // One handshake cycle: score any consumed result, log any accept, advance.
  task automatic step();
    #1;
    if (out_valid && out_ready) begin
      res_cnt++;
      if (exp_q.size() == 0) chk("extra_result", 66'd1, 66'd0);
      else chk("stream_result", {49'd0, c_out, sum}, {49'd0, exp_q.pop_front()});
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(ref16(a, b, c_in, sub));
      acc_cnt++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic op_check(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                          input logic tc, input logic ts, input logic [15:0] esum,
                          input logic ec, input logic eo, input logic ez);
    a = ta; b = tb; c_in = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk({tag, "_rdy"}, {65'd0, in_ready}, 66'd1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; a = ~ta; b = ~tb; c_in = ~tc; sub = ~ts;
    #1 chk({tag, "_lat1"}, {65'd0, out_valid}, 66'd0);
    @(posedge clk); @(negedge clk);
    #1 chk({tag, "_res"}, {46'd0, out_valid, esum, ec, eo, ez},
                          {46'd0, 1'b1, 16'(esum), ec, eo, ez} ^
                          {46'd0, out_valid ^ 1'b1, sum ^ esum, c_out ^ ec, ovf ^ eo, zero ^ ez});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] held;
    logic        held_v;
    repeat (2) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    #1;
    chk("rst_in_ready", {65'd0, in_ready}, 66'd0);
    chk("rst_state", {46'd0, out_valid, sum, c_out, ovf, zero}, 66'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    #1 chk("post_rst_ready", {65'd0, in_ready}, 66'd1);

    op_check("grp_carry", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
    op_check("wrap_zero", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    op_check("pos_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    op_check("sub_borrow",16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    op_check("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    op_check("add_cin",   16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0);
    op_check("sub_ign_cin",16'h0003,16'h0003, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    op_check("neg_ovf",   16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);

    // Back-to-back streaming
    @(posedge clk); @(negedge clk);
    exp_q.delete(); res_cnt = 0; acc_cnt = 0; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i < 8);
      a = 16'((i * 16'h2345) + 16'h0FFF);
      b = 16'(16'hF00F ^ (i * 16'h1111));
      sub = i[0]; c_in = i[1];
      if (i < 8) #1 chk("stream_rdy", {65'd0, in_ready}, 66'd1);
      step();
    end
    chk("stream_cnt", 66'(res_cnt), 66'd8);

    // Backpressure: 3 ops against a stalled output
    exp_q.delete(); res_cnt = 0; acc_cnt = 0; out_ready = 1'b0; held_v = 1'b0; held = '0;
    for (int c = 0; c < 4; c++) begin
      in_valid = (acc_cnt < 3);
      a = 16'h4000 + 16'(acc_cnt * 16'h0123); b = 16'h0F0F; sub = 1'b0; c_in = 1'b0;
      #1;
      if (out_valid) begin
        if (!held_v) begin held = sum; held_v = 1'b1; end
        else chk("bp_hold", {50'd0, sum}, {50'd0, held});
      end
      step();
    end
    chk("bp_accepts", 66'(acc_cnt), 66'd2);
    #1 chk("bp_in_ready", {65'd0, in_ready}, 66'd0);
    chk("bp_hold_end", {49'd0, out_valid, sum}, {49'd0, 1'b1, held});
    out_ready = 1'b1;
    for (int c = 0; c < 8 && res_cnt < 3; c++) begin
      in_valid = (acc_cnt < 3);
      a = 16'h4000 + 16'(acc_cnt * 16'h0123);
      step();
    end
    chk("bp_results", 66'(res_cnt), 66'd3);
    chk("bp_accepts_all", 66'(acc_cnt), 66'd3);

    // Reset with two operations in flight
    exp_q.delete(); acc_cnt = 0; out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1; a = 16'h1111 * 16'(c + 1); b = 16'h2222;
      step();
    end
    chk("fill_accepts", 66'(acc_cnt), 66'd2);
    rst = 1'b1; in_valid = 1'b1;
    #1 chk("rst_inflight_ready", {65'd0, in_ready}, 66'd0);
    @(posedge clk); @(negedge clk);
    #1 chk("rst_flush", {49'd0, out_valid, sum}, 66'd0);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; exp_q.delete(); res_cnt = 0;
    for (int c = 0; c < 4; c++) step();
    chk("rst_no_stale", 66'(res_cnt), 66'd0);

    // Wide and narrow instances against an arithmetic reference
    res_cnt = 0; acc_cnt = 0;
    for (int c = 0; c < 24; c++) begin
      iv64 = (c < 20); iv4 = (c < 20);
      a64 = {$urandom(), $urandom()}; b64 = {$urandom(), $urandom()};
      sb64 = 1'($urandom_range(0, 1)); ci64 = 1'($urandom_range(0, 1));
      a4 = 4'($urandom()); b4 = 4'($urandom());
      sb4 = 1'($urandom_range(0, 1)); ci4 = 1'($urandom_range(0, 1));
      if (c == 0) begin a64 = 64'h7FFF_FFFF_FFFF_FFFF; b64 = 64'd1; sb64 = 1'b0; ci64 = 1'b0; end
      if (c == 1) begin a4 = 4'h8; b4 = 4'h1; sb4 = 1'b1; end
      #1;
      if (ov64) begin
        res_cnt++;
        if (q64.size() == 0) chk("w64_extra", 66'd1, 66'd0);
        else chk("w64_result", {of64, co64, s64}, q64.pop_front());
      end
      if (ov4) begin
        acc_cnt++;
        if (q4.size() == 0) chk("w4_extra", 66'd1, 66'd0);
        else chk("w4_result", {60'd0, of4, co4, s4}, {60'd0, q4.pop_front()});
      end
      if (iv64 && ir64) q64.push_back(ref64(a64, b64, ci64, sb64));
      if (iv4 && ir4)   q4.push_back(ref4(a4, b4, ci4, sb4));
      @(posedge clk); @(negedge clk);
    end
    chk("w64_count", 66'(res_cnt), 66'd20);
    chk("w4_count", 66'(acc_cnt), 66'd20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cla_adder_pipe.md
Name: cla_adder_pipe

Overview:
- Parametrised, 2-stage pipelined carry-lookahead adder/subtractor with valid/ready handshakes on input and output.
- Built from 4-bit lookahead groups; a second lookahead level across group Pg/Gg replaces ripple between groups.
- Sits between operand registers and the ALU result mux.
- Accepts one operation per cycle with no stall; honours downstream backpressure.

Parameters:
- WIDTH, 16, operand width in bits; multiple of 4, range 4..64 (elaboration error otherwise).
- NG, WIDTH/4, number of 4-bit groups; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands/op valid this cycle.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry in (add mode only).
- sub  input  1  1 = A-B (B inverted, carry in forced 1, c_in ignored); 0 = A+B+c_in.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result.
- c_out  output  1  carry out of MSB (for sub: 1 = no borrow).
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  output  1  sum == 0.

Behaviour:
- Reset (rst=1 at posedge): s1_valid=0, out_valid=0, sum=0, c_out=0, ovf=0, zero=0. In-flight operations are discarded.
- in_ready is 0 during any cycle with rst=1.
- Stage 1 (S1), on accept:
  - Register bitwise P=a^b', G=a&b' and effective carry-in, where b'=b^{WIDTH{sub}}.
  - Register per-group Pg (AND of 4 P bits) and Gg (standard 4-bit group generate).
- Stage 2 (S2):
  - Second-level lookahead gives group carry-in: Cg[0]=cin_eff; Cg[k+1]=Gg[k] | (Pg[k]&Cg[k]) in two-level sum-of-products form, no ripple.
  - Within each group, bit carries come from 4-bit lookahead equations.
  - sum[i]=P[i]^carry_into_bit_i; c_out = carry out of group NG-1; ovf and zero as defined above. All S2 outputs are registered.
- Latency: exactly 2 clk edges from accept (in_valid&in_ready) to out_valid=1, with no stalls.
- Handshake:
  - s2_adv = !out_valid | out_ready.
  - in_ready = !rst & (!s1_valid | s2_adv).
  - S1 loads when in_valid&in_ready; otherwise, if s2_adv, s1_valid clears.
  - S2 loads S1 contents when s2_adv; out_valid <= s1_valid.
- Output stability: while out_valid=1 and out_ready=0, sum, c_out, ovf and zero hold stable. A full pipeline holds 2 ops; nothing is dropped or duplicated.
- Simultaneous events:
  - Accept, S1→S2 transfer and output consume may all occur in the same cycle, giving throughput 1/cycle.
  - out_ready may be 1 while out_valid=0; this has no effect.
- Wrap-around: sum is modulo 2^WIDTH; overflow is reported only via c_out and ovf.
- Inputs are sampled only on accept; changes on a, b, sub or c_in while not accepted are ignored.

Optional Feature:
- Macro: CLA_ADDER_PIPE_SAT_EN.
- When defined, adds input sat (1 bit), registered with the operands. With sat=1 and ovf=1, sum is clamped to signed max (0x7FFF for WIDTH=16) if the operand-sign case is positive overflow, else to signed min (0x8000). ovf and c_out still report the raw result; zero reflects the clamped sum.
- When undefined: no sat port; sum is always the wrapped result.

Test Plan:
- WIDTH=16, a=0x00FF, b=0x0001, sub=0, c_in=0, out_ready=1 → two edges later: out_valid=1, sum=0x0100, c_out=0, ovf=0, zero=0 (carry crosses group boundary).
- a=0xFFFF, b=0x0001, sub=0, c_in=0 → sum=0x0000, c_out=1, ovf=0, zero=1; repeat with a=0x7FFF → sum=0x8000, ovf=1 (with SAT_EN and sat=1: sum=0x7FFF, ovf=1).
- sub=1: a=0x0005, b=0x0007 → sum=0xFFFE, c_out=0; a=0x8000, b=0x0001 → sum=0x7FFF, ovf=1 (SAT_EN, sat=1: 0x8000).
- Back-to-back streaming of 8 ops with in_valid=1 and out_ready=1 → 8 results on consecutive cycles in order, in_ready constantly 1.
- Backpressure: out_ready=0 for 4 cycles while driving 3 ops → in_ready drops after 2 accepts; sum holds stable; after out_ready=1, all 3 results appear in order, none lost.
- Assert rst with 2 ops in flight → next cycle out_valid=0, sum=0, in_ready=0 during rst; no stale result emerges after deassert. Sweep WIDTH=4,32,64 with random ops against a+b' reference.
